// File: rtl/cu_pkg.sv
// Shared control-unit definitions. The instruction decoder also uses this
// package, so the opcode constants live here rather than in cu_fsm.
package cu_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;

   // In SYSTEM instructions, func3 = 000 means MRET. All other func3
   // values are CSR accesses.
   localparam logic [2:0] F3_MRET = 3'b000;

endpackage

// File: rtl/intr_sync.sv
// Flop-chain synchronizer that brings the asynchronous interrupt request
// into the clk domain. The clear is synchronous and active-low, so the
// chain flushes together with the FSM reset.
module intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_reg;

   // Shift the raw request one stage per clock, and clear the chain on reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
      end
   end

   assign sync_out = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/cu_fsm.sv
// Multi-cycle control unit for the Otter MCU. It steps each instruction
// through FETCH, EXEC and an optional WB state, and decides when the PC,
// the register file, data memory and the CSRs commit. It also handles
// interrupt entry.
module cu_fsm #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       intr,
   input  logic       csr_mie,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   output logic       pc_rst,
   output logic       pc_we,
   output logic       rf_we,
   output logic       mem_rden1,
   output logic       mem_rden2,
   output logic       mem_we2,
   output logic       csr_we,
   output logic       int_taken,
   output logic       mret_exec
);
   import cu_pkg::*;

   state_t state_reg;
   state_t state_next;
   logic   intr_synced;
   logic   int_pend;

   intr_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_intr_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_in(intr),
      .sync_out(intr_synced)
   );

   // csr_mie is used as it is in this cycle. During MRET this is the value
   // before MIE is restored.
   assign int_pend = intr_synced & csr_mie;

   // State register. While reset is held, the FSM stays in INIT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and commit enables. Outputs depend on the state, and
   // in EXEC also on the instruction being executed.
   always_comb begin
      pc_rst     = 1'b0;
      pc_we      = 1'b0;
      rf_we      = 1'b0;
      mem_rden1  = 1'b0;
      mem_rden2  = 1'b0;
      mem_we2    = 1'b0;
      csr_we     = 1'b0;
      int_taken  = 1'b0;
      mret_exec  = 1'b0;
      state_next = state_reg;
      unique case (state_reg)
         ST_INIT: begin
            pc_rst     = 1'b1;
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_rden1  = 1'b1;
            state_next = ST_EXEC;
         end
         ST_EXEC: begin
            state_next = int_pend ? ST_INTR : ST_FETCH;
            case (opcode)
               OP_LOAD: begin
                  // The PC is not advanced here. It advances in WB.
                  mem_rden2  = 1'b1;
                  state_next = ST_WB;
               end
               OP_STORE: begin
                  mem_we2 = 1'b1;
                  pc_we   = 1'b1;
               end
               OP_BRANCH: begin
                  pc_we = 1'b1;
               end
               OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                  rf_we = 1'b1;
                  pc_we = 1'b1;
               end
               OP_SYS: begin
                  pc_we = 1'b1;
                  if (func3 == F3_MRET) begin
                     mret_exec = 1'b1;
                  end else begin
                     csr_we = 1'b1;
                     rf_we  = 1'b1;
                  end
               end
               default: begin
                  // Unknown opcodes only move the PC, so they act as a NOP.
                  pc_we = 1'b1;
               end
            endcase
         end
         ST_WB: begin
            rf_we      = 1'b1;
            pc_we      = 1'b1;
            state_next = int_pend ? ST_INTR : ST_FETCH;
         end
         ST_INTR: begin
            int_taken  = 1'b1;
            pc_we      = 1'b1;
            state_next = ST_FETCH;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed testbench for cu_fsm. All outputs are packed into one vector
// and compared against hand-computed constants after each clock edge.
// Bit order: pc_rst pc_we rf_we mem_rden1 mem_rden2 mem_we2 csr_we int_taken mret_exec
module tb_cu_fsm;

   localparam logic [8:0] E_INIT  = 9'h100;
   localparam logic [8:0] E_FETCH = 9'h020;
   localparam logic [8:0] E_ALU   = 9'h0C0;
   localparam logic [8:0] E_LDEX  = 9'h010;
   localparam logic [8:0] E_WB    = 9'h0C0;
   localparam logic [8:0] E_STORE = 9'h088;
   localparam logic [8:0] E_NOP   = 9'h080;
   localparam logic [8:0] E_CSR   = 9'h0C4;
   localparam logic [8:0] E_MRET  = 9'h081;
   localparam logic [8:0] E_INTR  = 9'h082;

   logic       clk;
   logic       rst_n;
   logic       intr;
   logic       csr_mie;
   logic [6:0] opcode;
   logic [2:0] func3;
   logic       pc_rst, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2;
   logic       csr_we, int_taken, mret_exec;
   logic [8:0] outs;

   int total;
   int bad;

   cu_fsm #(
      .SYNC_STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .intr     (intr),
      .csr_mie  (csr_mie),
      .opcode   (opcode),
      .func3    (func3),
      .pc_rst   (pc_rst),
      .pc_we    (pc_we),
      .rf_we    (rf_we),
      .mem_rden1(mem_rden1),
      .mem_rden2(mem_rden2),
      .mem_we2  (mem_we2),
      .csr_we   (csr_we),
      .int_taken(int_taken),
      .mret_exec(mret_exec)
   );

   assign outs = {pc_rst, pc_we, rf_we, mem_rden1, mem_rden2, mem_we2,
                  csr_we, int_taken, mret_exec};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Move 2 time units past the next rising edge. Outputs are sampled there,
   // away from the clock edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      intr    = 1'b0;
      csr_mie = 1'b0;
      opcode  = 7'b0000000;
      func3   = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (outs !== E_INIT) begin
            $display("FAIL reset_hold[%0d] got=%h exp=%h", i, outs, E_INIT);
            bad++;
         end
         $display("reset cycle %0d outs=%h", i, outs);
      end
      rst_n  = 1'b1;
      opcode = 7'b0110011;
      step();
      total++;
      if (outs !== E_FETCH) begin
         $display("FAIL reset_to_fetch got=%h exp=%h", outs, E_FETCH);
         bad++;
      end
      $display("reset release -> fetch outs=%h", outs);
   endtask

   // On entry the DUT is in FETCH. On exit it is in FETCH again.
   task automatic test_add_load();
      logic [8:0] exp_seq [5];
      exp_seq = '{E_ALU, E_FETCH, E_LDEX, E_WB, E_FETCH};
      opcode = 7'b0110011;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 1) opcode = 7'b0000011;
         total++;
         if (outs !== exp_seq[i]) begin
            $display("FAIL add_load[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            bad++;
         end
         $display("add/load cycle %0d outs=%h", i, outs);
      end
   endtask

   task automatic test_store_nop();
      logic [8:0] exp_seq [4];
      exp_seq = '{E_STORE, E_FETCH, E_NOP, E_FETCH};
      opcode = 7'b0100011;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 1) opcode = 7'b0001111;
         total++;
         if (outs !== exp_seq[i]) begin
            $display("FAIL store_nop[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            bad++;
         end
         $display("store/nop cycle %0d outs=%h", i, outs);
      end
   endtask

   task automatic test_csr_mret();
      logic [8:0] exp_seq [4];
      exp_seq = '{E_CSR, E_FETCH, E_MRET, E_FETCH};
      opcode = 7'b1110011;
      func3  = 3'b001;
      for (int i = 0; i < 4; i++) begin
         step();
         if (i == 1) func3 = 3'b000;
         total++;
         if (outs !== exp_seq[i]) begin
            $display("FAIL csr_mret[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            bad++;
         end
         $display("csr/mret cycle %0d outs=%h", i, outs);
      end
   endtask

   // intr is raised in FETCH. The second flop edge makes it visible only in
   // the following FETCH, so the interrupt is taken after the next EXEC.
   task automatic test_interrupt();
      logic [8:0] exp_seq [7];
      exp_seq = '{E_ALU, E_FETCH, E_ALU, E_INTR, E_FETCH, E_ALU, E_FETCH};
      opcode  = 7'b0110011;
      func3   = 3'b000;
      csr_mie = 1'b1;
      intr    = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (i == 3) begin
            // Acknowledge: the source drops intr, and the CSR file clears MIE.
            intr    = 1'b0;
            csr_mie = 1'b0;
         end
         total++;
         if (outs !== exp_seq[i]) begin
            $display("FAIL intr_taken[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            bad++;
         end
         $display("intr cycle %0d outs=%h", i, outs);
      end
   endtask

   task automatic test_interrupt_masked();
      int taken;
      taken   = 0;
      opcode  = 7'b0110011;
      csr_mie = 1'b0;
      intr    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (int_taken === 1'b1) taken++;
         total++;
         if (outs !== ((i % 2 == 0) ? E_ALU : E_FETCH)) begin
            $display("FAIL intr_masked[%0d] got=%h exp=%h", i, outs,
                     (i % 2 == 0) ? E_ALU : E_FETCH);
            bad++;
         end
      end
      total++;
      if (taken != 0) begin
         $display("FAIL intr_masked_count got=%0d exp=0", taken);
         bad++;
      end
      $display("masked intr: int_taken pulses=%0d", taken);
      intr = 1'b0;
   endtask

   task automatic test_reset_in_wb();
      logic [8:0] exp_seq [5];
      exp_seq = '{E_LDEX, E_WB, E_INIT, E_INIT, E_FETCH};
      opcode = 7'b0000011;
      for (int i = 0; i < 5; i++) begin
         step();
         if (i == 1) rst_n = 1'b0;
         if (i == 3) rst_n = 1'b1;
         total++;
         if (outs !== exp_seq[i]) begin
            $display("FAIL reset_in_wb[%0d] got=%h exp=%h", i, outs, exp_seq[i]);
            bad++;
         end
         $display("reset-in-wb cycle %0d outs=%h", i, outs);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add_load();
      test_store_nop();
      test_csr_mret();
      test_interrupt();
      test_interrupt_masked();
      test_reset_in_wb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
